// File: rtl/reaction_timer_if.sv
// Start-lights reaction timer bus.
// Timer side is master, sequence/display side is slave.
interface reaction_timer_if #(
  parameter int CNT_W = 14
);
  logic             tick;
  logic             trigger;
  logic             lights_out;
  logic             button;
  logic             busy;
  logic             result_valid;
  logic [CNT_W-1:0] result_ms;
  logic             jump_start;
  logic             no_response;
  logic [CNT_W-1:0] best_ms;

  modport master (
    input  tick, trigger, lights_out, button,
    output busy, result_valid, result_ms,
    output jump_start, no_response, best_ms
  );

  modport slave (
    output tick, trigger, lights_out, button,
    input  busy, result_valid, result_ms,
    input  jump_start, no_response, best_ms
  );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer for the start-lights sequence:
// ms from lights-out to press, jump starts, best time.
module reaction_timer #(
  parameter int CNT_W  = 14,
  parameter int MAX_MS = 9999
) (
  input  logic            clk,
  input  logic            rst_n,
  reaction_timer_if.master bus
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_MS);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    JUMP,
    NORESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_cnt;
  logic             btn_prev;
  logic             press;

  assign press    = bus.button & ~btn_prev;
  assign next_cnt = count + 1'b1;
  assign bus.busy = (state == ARMED) ||
                    (state == TIMING);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      count            <= '0;
      btn_prev         <= 1'b1;
      bus.result_valid <= 1'b0;
      bus.result_ms    <= '0;
      bus.jump_start   <= 1'b0;
      bus.no_response  <= 1'b0;
      bus.best_ms      <= MAX;
    end else begin
      btn_prev         <= bus.button;
      bus.result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.trigger) begin
            state <= ARMED;
            count <= '0;
          end
        end
        ARMED: begin
          // A press wins even when lights go out in the same cycle.
          if (press) begin
            state            <= JUMP;
            bus.jump_start   <= 1'b1;
            bus.result_ms    <= '0;
            bus.result_valid <= 1'b1;
          end else if (bus.lights_out) begin
            state <= TIMING;
            count <= '0;
          end
        end
        TIMING: begin
          if (press) begin
            state            <= DONE;
            bus.result_ms    <= count;
            bus.jump_start   <= 1'b0;
            bus.no_response  <= 1'b0;
            bus.result_valid <= 1'b1;
            if (count < bus.best_ms)
              bus.best_ms <= count;
          end else if (bus.tick) begin
            count <= next_cnt;
            if (next_cnt == MAX) begin
              state            <= NORESP;
              bus.result_ms    <= MAX;
              bus.no_response  <= 1'b1;
              bus.result_valid <= 1'b1;
            end
          end
        end
        DONE, JUMP, NORESP: begin
          if (bus.trigger) begin
            state           <= ARMED;
            count           <= '0;
            bus.jump_start  <= 1'b0;
            bus.no_response <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Randomized bench for reaction_timer against a
// per-attempt arithmetic model of expected results.
module tb_reaction_timer;

  localparam int CNT_W  = 14;
  localparam int MAX_MS = 9999;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   best_exp;

  reaction_timer_if #(.CNT_W(CNT_W)) bus ();

  reaction_timer #(
    .CNT_W (CNT_W),
    .MAX_MS(MAX_MS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_noise(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus.trigger    = ($urandom_range(0, 7) == 0);
      bus.lights_out = ($urandom_range(0, 7) == 0);
      step();
      bus.trigger    = 1'b0;
      bus.lights_out = 1'b0;
    end
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    step();
    bus.trigger = 1'b0;
  endtask

  task automatic pulse_lights();
    bus.lights_out = 1'b1;
    step();
    bus.lights_out = 1'b0;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  // n ticks counted, then press (optionally on a tick).
  task automatic attempt_valid(input int n,
                               input bit co);
    int r;
    bus.button = 1'b0;
    step();
    pulse_trigger();
    check("armed_busy", 32'(bus.busy), 1);
    check("rearm_jump", 32'(bus.jump_start), 0);
    check("rearm_noresp", 32'(bus.no_response), 0);
    r = $urandom_range(0, 3);
    for (int i = 0; i < r; i++) pulse_tick();
    pulse_lights();
    for (int i = 0; i < n; i++) begin
      idle_noise($urandom_range(0, 2));
      pulse_tick();
    end
    bus.button = 1'b1;
    bus.tick   = co;
    step();
    bus.tick   = 1'b0;
    if (n < best_exp) best_exp = n;
    check("done_valid", 32'(bus.result_valid), 1);
    check("done_ms", 32'(bus.result_ms), 32'(n));
    check("done_best", 32'(bus.best_ms),
          32'(best_exp));
    check("done_jump", 32'(bus.jump_start), 0);
    check("done_noresp", 32'(bus.no_response), 0);
    check("done_busy", 32'(bus.busy), 0);
    step();
    check("done_strobe", 32'(bus.result_valid), 0);
    check("done_hold", 32'(bus.result_ms), 32'(n));
    bus.button = 1'b0;
  endtask

  task automatic attempt_jump(input bit co);
    int r;
    bus.button = 1'b0;
    step();
    pulse_trigger();
    r = $urandom_range(0, 3);
    for (int i = 0; i < r; i++) pulse_tick();
    bus.button     = 1'b1;
    bus.lights_out = co;
    step();
    bus.lights_out = 1'b0;
    check("jump_valid", 32'(bus.result_valid), 1);
    check("jump_flag", 32'(bus.jump_start), 1);
    check("jump_ms", 32'(bus.result_ms), 0);
    check("jump_best", 32'(bus.best_ms),
          32'(best_exp));
    check("jump_busy", 32'(bus.busy), 0);
    step();
    check("jump_strobe", 32'(bus.result_valid), 0);
    bus.button = 1'b0;
    step();
    pulse_lights();
    check("jump_late_lo", 32'(bus.busy), 0);
    check("jump_hold", 32'(bus.jump_start), 1);
  endtask

  task automatic attempt_noresp();
    bus.button = 1'b0;
    step();
    pulse_trigger();
    pulse_lights();
    for (int i = 0; i < MAX_MS; i++) begin
      if (i == MAX_MS - 1) begin
        check("nr_pre_valid",
              32'(bus.result_valid), 0);
        check("nr_pre_busy", 32'(bus.busy), 1);
      end
      pulse_tick();
    end
    check("nr_valid", 32'(bus.result_valid), 1);
    check("nr_flag", 32'(bus.no_response), 1);
    check("nr_ms", 32'(bus.result_ms), MAX_MS);
    check("nr_best", 32'(bus.best_ms),
          32'(best_exp));
    check("nr_jump", 32'(bus.jump_start), 0);
    check("nr_busy", 32'(bus.busy), 0);
    // Late press is ignored in the end state.
    bus.button = 1'b1;
    step();
    step();
    check("nr_late_press", 32'(bus.result_ms),
          MAX_MS);
    bus.button = 1'b0;
  endtask

  task automatic check_reset_state(input string t);
    check({t, "_busy"}, 32'(bus.busy), 0);
    check({t, "_valid"}, 32'(bus.result_valid), 0);
    check({t, "_ms"}, 32'(bus.result_ms), 0);
    check({t, "_best"}, 32'(bus.best_ms), MAX_MS);
    check({t, "_jump"}, 32'(bus.jump_start), 0);
    check({t, "_noresp"}, 32'(bus.no_response), 0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    best_exp       = MAX_MS;
    rst_n          = 1'b0;
    bus.tick       = 1'b0;
    bus.trigger    = 1'b0;
    bus.lights_out = 1'b0;
    bus.button     = 1'b0;
    step();
    step();
    check_reset_state("rst");
    rst_n = 1'b1;
    step();

    attempt_valid(237, 1'b0);
    attempt_jump(1'b0);
    attempt_jump(1'b1);
    attempt_noresp();
    attempt_valid(99, 1'b1);
    attempt_valid(300, 1'b0);

    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 3))
        0, 1: attempt_valid($urandom_range(1, 400),
                            1'($urandom_range(0, 1)));
        2: attempt_jump(1'($urandom_range(0, 1)));
        default: attempt_valid($urandom_range(0, 30),
                               1'($urandom_range(0, 1)));
      endcase
    end

    // Reset mid-timing with the button held down.
    pulse_trigger();
    pulse_lights();
    for (int i = 0; i < 50; i++) pulse_tick();
    bus.button = 1'b1;
    rst_n      = 1'b0;
    step();
    check_reset_state("midrst");
    rst_n = 1'b1;
    step();
    best_exp = MAX_MS;
    pulse_trigger();
    pulse_lights();
    for (int i = 0; i < 5; i++) pulse_tick();
    check("held_no_press", 32'(bus.busy), 1);
    check("held_no_valid", 32'(bus.result_valid), 0);
    bus.button = 1'b0;
    step();
    bus.button = 1'b1;
    step();
    check("post_rst_valid", 32'(bus.result_valid), 1);
    check("post_rst_ms", 32'(bus.result_ms), 5);
    check("post_rst_best", 32'(bus.best_ms), 5);
    bus.button = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
